// File: rtl/rm_stage_arb_if.sv
// rm_stage_arb_if: stream, report-capture and report-FIFO signals of rm_stage_arb.
// master = producer/consumer side, slave = the stage itself.
interface rm_stage_arb_if #(
    parameter int unsigned SYM_W      = 8,
    parameter int unsigned NUM_CH     = 40,
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned TS_W       = 16,
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic              run;
    logic [SYM_W-1:0]  top_symbols;
    logic              flush;
    logic [NUM_CH-1:0] rpt_in;
    logic [SYM_W-1:0]  out_symbols;
    logic              out_flush;
    logic              rpt_valid;
    logic              rpt_ready;
    logic [IDX_W-1:0]  rpt_chan;
    logic [TS_W-1:0]   rpt_ts;
    logic              rpt_overflow;
    logic              rpt_clear;
    logic [LW-1:0]     fifo_level;

    modport master (
        output run, top_symbols, flush, rpt_in, rpt_ready, rpt_clear,
        input  out_symbols, out_flush, rpt_valid, rpt_chan, rpt_ts, rpt_overflow, fifo_level
    );

    modport slave (
        input  run, top_symbols, flush, rpt_in, rpt_ready, rpt_clear,
        output out_symbols, out_flush, rpt_valid, rpt_chan, rpt_ts, rpt_overflow, fifo_level
    );
endinterface

// File: rtl/rm_stage_arb.sv
// rm_stage_arb: symbol pipeline stage plus round-robin report arbiter feeding a FWFT report FIFO.
// Define RM_STAGE_TIMESTAMP_EN to timestamp each report with the enqueue-cycle count.
module rm_stage_arb #(
    parameter int unsigned SYM_W      = 8,
    parameter int unsigned NUM_CH     = 40,
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned TS_W       = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    rm_stage_arb_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [SYM_W-1:0]  r_out_sym;
    logic              r_out_flush;
    logic [NUM_CH-1:0] r_pend;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_mem_chan [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;
    logic              r_ovf;

    logic              w_restart;
    logic              w_valid;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [NUM_CH-1:0] w_capture;
    logic [NUM_CH-1:0] w_gnt_vec;
    logic [NUM_CH-1:0] w_pend_nxt;
    logic              w_ovf_set;
    logic              w_lo_vld;
    logic              w_hi_vld;
    logic [IDX_W-1:0]  w_lo_idx;
    logic [IDX_W-1:0]  w_hi_idx;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic [IDX_W-1:0]  w_rr_nxt;

    assign w_restart = bus.run & bus.flush;
    assign w_valid   = (r_level != '0);
    assign w_full    = (r_level == LW'(FIFO_DEPTH));
    assign w_pop     = w_valid & bus.rpt_ready;
    assign w_capture = bus.run ? bus.rpt_in : '0;

    // Lowest pending index overall and lowest at/above rr_ptr; the latter wins when present.
    always_comb begin
        w_lo_vld = 1'b0;
        w_hi_vld = 1'b0;
        w_lo_idx = '0;
        w_hi_idx = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (r_pend[IDX_W'(i)]) begin
                w_lo_vld = 1'b1;
                w_lo_idx = IDX_W'(i);
                if (IDX_W'(i) >= r_rr_ptr) begin
                    w_hi_vld = 1'b1;
                    w_hi_idx = IDX_W'(i);
                end
            end
        end
    end

    assign w_gnt_idx  = w_hi_vld ? w_hi_idx : w_lo_idx;
    assign w_push     = w_lo_vld & (~w_full | w_pop);
    assign w_gnt_vec  = w_push ? (NUM_CH'(1) << w_gnt_idx) : '0;
    assign w_rr_nxt   = (w_gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
    assign w_pend_nxt = (r_pend & ~w_gnt_vec) | w_capture;
    // A new event on a channel still waiting for its grant is merged and lost.
    assign w_ovf_set  = ~w_restart & (|(w_capture & r_pend & ~w_gnt_vec));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_sym   <= '0;
            r_out_flush <= 1'b0;
            r_pend      <= '0;
            r_rr_ptr    <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (bus.run) begin
                r_out_sym   <= bus.top_symbols;
                r_out_flush <= bus.flush;
            end
            if (w_restart) begin
                r_pend   <= '0;
                r_rr_ptr <= '0;
                r_wptr   <= '0;
                r_rptr   <= '0;
                r_level  <= '0;
            end else begin
                r_pend <= w_pend_nxt;
                if (w_push) begin
                    r_rr_ptr <= w_rr_nxt;
                    r_wptr   <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LW'(1);
                    2'b01:   r_level <= r_level - LW'(1);
                    default: r_level <= r_level;
                endcase
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (bus.rpt_clear) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Storage needs no reset: entries are only visible while the level is non-zero.
    always_ff @(posedge clk) begin
        if (w_push && !w_restart) begin
            r_mem_chan[r_wptr] <= w_gnt_idx;
        end
    end

`ifdef RM_STAGE_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_mem_ts [FIFO_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts <= '0;
        end else if (bus.run) begin
            r_ts <= bus.flush ? '0 : r_ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !w_restart) begin
            r_mem_ts[r_wptr] <= r_ts;
        end
    end

    assign bus.rpt_ts = w_valid ? r_mem_ts[r_rptr] : '0;
`else
    assign bus.rpt_ts = TS_W'(0);
`endif

    assign bus.out_symbols  = r_out_sym;
    assign bus.out_flush    = r_out_flush;
    assign bus.rpt_valid    = w_valid;
    assign bus.rpt_chan     = w_valid ? r_mem_chan[r_rptr] : '0;
    assign bus.rpt_overflow = r_ovf;
    assign bus.fifo_level   = r_level;
endmodule

// File: tb/tb_rm_stage_arb.sv
// tb_rm_stage_arb: scoreboard bench for rm_stage_arb; expected reports are queued at stimulus
// time and compared as each FIFO head is popped, plus direct checks of stream/FIFO state.
module tb_rm_stage_arb;
    localparam int unsigned SYM_W      = 8;
    localparam int unsigned NUM_CH     = 40;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned TS_W       = 16;
    localparam int unsigned FIFO_DEPTH = 8;
`ifdef RM_STAGE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [IDX_W-1:0] chan;
        logic [TS_W-1:0]  ts;
    } rpt_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    rm_stage_arb_if #(.SYM_W(SYM_W), .NUM_CH(NUM_CH), .IDX_W(IDX_W), .TS_W(TS_W),
                      .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    rm_stage_arb #(.SYM_W(SYM_W), .NUM_CH(NUM_CH), .IDX_W(IDX_W), .TS_W(TS_W),
                   .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    rpt_t            sb_q[$];
    int              n_chk  = 0;
    int              n_fail = 0;
    logic [TS_W-1:0] ts_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Timestamp reference: counts run cycles, zeroed by reset or a qualified flush.
    always @(posedge clk or negedge reset) begin
        if (!reset)        ts_m <= '0;
        else if (bus.run)  ts_m <= bus.flush ? '0 : ts_m + TS_W'(1);
    end

    function automatic logic [NUM_CH-1:0] bit_of(input int ch);
        return NUM_CH'(1) << ch;
    endfunction

    // Queue an expected report granted 'off' cycles after the current cycle's timestamp.
    task automatic expect_rpt(input int ch, input int off);
        rpt_t e;
        e.chan = IDX_W'(ch);
        e.ts   = TS_EN ? TS_W'(32'(ts_m) + off) : '0;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sym"},   32'(bus.out_symbols),  0);
        check({tag, "_flush"}, 32'(bus.out_flush),    0);
        check({tag, "_valid"}, 32'(bus.rpt_valid),    0);
        check({tag, "_level"}, 32'(bus.fifo_level),   0);
        check({tag, "_chan"},  32'(bus.rpt_chan),     0);
        check({tag, "_ts"},    32'(bus.rpt_ts),       0);
        check({tag, "_ovf"},   32'(bus.rpt_overflow), 0);
    endtask

    // Scoreboard: the head visible now is popped at the next rising edge.
    always @(negedge clk) begin
        if (reset && bus.rpt_valid && bus.rpt_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_chan", 32'(bus.rpt_chan), 32'hFFFF_FFFF);
            end else begin
                rpt_t e;
                e = sb_q.pop_front();
                check("sb_chan", 32'(bus.rpt_chan), 32'(e.chan));
                check("sb_ts",   32'(bus.rpt_ts),   32'(e.ts));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        bus.run         = 1'b0;
        bus.top_symbols = '0;
        bus.flush       = 1'b0;
        bus.rpt_in      = '0;
        bus.rpt_ready   = 1'b0;
        bus.rpt_clear   = 1'b0;
        #12;
        check_all_zero("reset");

        // First report latency and timestamp.
        @(negedge clk);
        reset         = 1'b1;
        bus.run       = 1'b1;
        bus.rpt_ready = 1'b1;
        tick(1);
        guard = 0;
        while (ts_m != TS_W'(3) && guard < 20) begin
            tick(1);
            guard++;
        end
        check("ts_reach3", 32'(ts_m), 3);
        bus.rpt_in = bit_of(5);
        expect_rpt(5, 1);
        tick(1);
        bus.rpt_in = '0;
        check("lat_valid_1cyc", 32'(bus.rpt_valid), 0);
        tick(1);
        check("lat_valid_2cyc", 32'(bus.rpt_valid), 1);
        check("first_chan", 32'(bus.rpt_chan), 5);
        check("first_ts", 32'(bus.rpt_ts), TS_EN ? 4 : 0);
        tick(3);

        // Move rr_ptr to 8, then three simultaneous requests.
        bus.rpt_in = bit_of(7);
        expect_rpt(7, 1);
        tick(1);
        bus.rpt_in = '0;
        tick(3);
        bus.rpt_in = bit_of(0) | bit_of(7) | bit_of(39);
        expect_rpt(39, 1);
        expect_rpt(0, 2);
        expect_rpt(7, 3);
        tick(1);
        bus.rpt_in = '0;
        tick(1);
        check("rr_first_39", 32'(bus.rpt_chan), 39);
        tick(1);
        check("rr_wrap_0", 32'(bus.rpt_chan), 0);
        tick(1);
        check("rr_then_7", 32'(bus.rpt_chan), 7);
        tick(3);
        check("rr_sb_drained", 32'(sb_q.size()), 0);

        // Back-to-back event on the channel being granted is a new report, not an overflow.
        bus.rpt_in = bit_of(25);
        expect_rpt(25, 1);
        expect_rpt(25, 2);
        tick(2);
        bus.rpt_in = '0;
        tick(4);
        check("regrant_no_ovf", 32'(bus.rpt_overflow), 0);
        check("regrant_sb_drained", 32'(sb_q.size()), 0);

        // Fill the FIFO; the ninth channel waits, a repeat on it overflows.
        bus.rpt_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            bus.rpt_in = bit_of(10 + k);
            if (k < 8) expect_rpt(10 + k, 1);
            tick(1);
        end
        bus.rpt_in = '0;
        tick(2);
        check("full_level", 32'(bus.fifo_level), 8);
        check("full_no_ovf", 32'(bus.rpt_overflow), 0);
        bus.rpt_in = bit_of(18);
        tick(1);
        bus.rpt_in = '0;
        check("ovf_set", 32'(bus.rpt_overflow), 1);
        bus.rpt_in    = bit_of(18);
        bus.rpt_clear = 1'b1;
        tick(1);
        bus.rpt_in = '0;
        check("ovf_set_beats_clear", 32'(bus.rpt_overflow), 1);
        tick(1);
        bus.rpt_clear = 1'b0;
        check("ovf_cleared", 32'(bus.rpt_overflow), 0);
        bus.rpt_ready = 1'b1;
        expect_rpt(18, 0);
        tick(1);
        check("full_pushpop_level", 32'(bus.fifo_level), 8);
        tick(10);
        check("full_drained_level", 32'(bus.fifo_level), 0);
        check("full_sb_drained", 32'(sb_q.size()), 0);

        // run=0 freezes stream and capture but reports still drain.
        bus.top_symbols = 8'h3C;
        bus.rpt_in      = bit_of(20);
        expect_rpt(20, 1);
        tick(1);
        check("sym_3c", 32'(bus.out_symbols), 32'h3C);
        bus.run         = 1'b0;
        bus.top_symbols = 8'hA5;
        bus.flush       = 1'b1;
        bus.rpt_in      = bit_of(21);
        tick(1);
        check("hold_sym", 32'(bus.out_symbols), 32'h3C);
        check("hold_flush", 32'(bus.out_flush), 0);
        check("stall_drain_valid", 32'(bus.rpt_valid), 1);
        check("stall_drain_chan", 32'(bus.rpt_chan), 20);
        bus.flush  = 1'b0;
        bus.rpt_in = '0;
        tick(1);
        check("hold_sym2", 32'(bus.out_symbols), 32'h3C);
        check("stall_popped", 32'(bus.rpt_valid), 0);
        bus.run = 1'b1;
        tick(1);
        check("resume_sym", 32'(bus.out_symbols), 32'hA5);
        tick(2);

        // Flush with three queued entries and one still pending.
        bus.rpt_ready = 1'b0;
        bus.rpt_in    = bit_of(1) | bit_of(3) | bit_of(4) | bit_of(6);
        tick(1);
        bus.rpt_in = '0;
        tick(3);
        check("preflush_level", 32'(bus.fifo_level), 3);
        bus.flush  = 1'b1;
        bus.rpt_in = bit_of(2);
        tick(1);
        check("flush_valid", 32'(bus.rpt_valid), 0);
        check("flush_level", 32'(bus.fifo_level), 0);
        check("flush_out", 32'(bus.out_flush), 1);
        bus.flush     = 1'b0;
        bus.rpt_ready = 1'b1;
        bus.rpt_in    = bit_of(0) | bit_of(9);
        expect_rpt(0, 1);
        expect_rpt(9, 2);
        tick(1);
        bus.rpt_in = '0;
        tick(6);
        check("postflush_sb_drained", 32'(sb_q.size()), 0);
        check("postflush_empty", 32'(bus.rpt_valid), 0);

        // Asynchronous reset between edges with a report queued.
        bus.rpt_ready   = 1'b0;
        bus.top_symbols = 8'h5A;
        bus.rpt_in      = bit_of(11);
        tick(1);
        bus.rpt_in = '0;
        tick(1);
        check("prereset_valid", 32'(bus.rpt_valid), 1);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset         = 1'b1;
        bus.rpt_ready = 1'b1;
        tick(5);
        check("postreset_no_rpt", 32'(bus.rpt_valid), 0);
        check("postreset_sb_empty", 32'(sb_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
